// File: rtl/cpu_datapath.sv
// CPU datapath: PC, IR, accumulator, register file, ALU and z/c flags, driven by controller strobes.
// Every strobe takes effect at the next rising clk edge; no backpressure, state simply holds without strobes.
module cpu_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic [7:0]        instr_in,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic              LoadIR,
  input  logic              IncPC,
  input  logic              SelPC,
  input  logic              LoadPC,
  input  logic              LoadReg,
  input  logic              LoadAcc,
  input  logic [1:0]        SelACC,
  input  logic [3:0]        SelALU,
  output logic [3:0]        op,
  output logic              z,
  output logic              c,
  output logic [DATA_W-1:0] acc_out
);

  localparam int NREG = 1 << REG_AW;
  localparam int WIDE = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] field;
  } instr_t;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_SHL = 4'b1011;
  localparam logic [3:0] ALU_SHR = 4'b1100;

  localparam logic [3:0] OP_JZRS = 4'b0110;
  localparam logic [3:0] OP_JZIM = 4'b0111;
  localparam logic [3:0] OP_JCRS = 4'b1000;
  localparam logic [3:0] OP_JCIM = 4'b1010;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_REG = 2'b10;
  localparam logic [1:0] SRC_IMM = 2'b11;

  instr_t              ir;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   rf [NREG];

  logic [REG_AW-1:0]   idx;
  logic [DATA_W-1:0]   rd;
  logic [DATA_W-1:0]   imm_d;
  logic [ADDR_W-1:0]   imm_a;
  logic [WIDE-1:0]     rd_wide;
  logic [ADDR_W-1:0]   reg_tgt;
  logic                jump_cond;
  logic [ADDR_W-1:0]   pc_nxt;

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_cout;

  logic [DATA_W-1:0]   acc_nxt;
  logic                upd_z;
  logic                upd_c;

  assign idx     = ir.field[REG_AW-1:0];
  assign rd      = rf[idx];
  assign imm_d   = DATA_W'(ir.field);
  assign imm_a   = ADDR_W'(ir.field);
  assign rd_wide = WIDE'(rd);
  assign reg_tgt = rd_wide[ADDR_W-1:0];

  assign op      = ir.opcode;
  assign pc_addr = pc;
  assign acc_out = acc;

  // Branch condition comes from the IR currently held, not the word being loaded.
  always_comb begin
    jump_cond = 1'b0;
    case (ir.opcode)
      OP_JZRS, OP_JZIM: jump_cond = z;
      OP_JCRS, OP_JCIM: jump_cond = c;
      default:          jump_cond = 1'b0;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    if (LoadPC && jump_cond) begin
      pc_nxt = SelPC ? reg_tgt : imm_a;
    end else if (IncPC) begin
      pc_nxt = pc + ADDR_W'(1);
    end
  end

  assign sum  = {1'b0, acc} + {1'b0, rd};
  assign diff = {1'b0, acc} - {1'b0, rd};

  // The borrow bit of the widened subtraction is exactly A < B.
  always_comb begin
    alu_res  = acc;
    alu_cout = c;
    case (SelALU)
      ALU_ADD: begin
        alu_res  = sum[DATA_W-1:0];
        alu_cout = sum[DATA_W];
      end
      ALU_SUB: begin
        alu_res  = diff[DATA_W-1:0];
        alu_cout = diff[DATA_W];
      end
      ALU_NOR: begin
        alu_res  = ~(acc | rd);
        alu_cout = 1'b0;
      end
      ALU_SHL: begin
        alu_res  = {acc[DATA_W-2:0], 1'b0};
        alu_cout = acc[DATA_W-1];
      end
      ALU_SHR: begin
        alu_res  = {1'b0, acc[DATA_W-1:1]};
        alu_cout = acc[0];
      end
      default: begin
        alu_res  = acc;
        alu_cout = c;
      end
    endcase
  end

  // SelACC=01 is reserved: accumulator and both flags hold.
  always_comb begin
    acc_nxt = acc;
    upd_z   = 1'b0;
    upd_c   = 1'b0;
    case (SelACC)
      SRC_ALU: begin
        acc_nxt = alu_res;
        upd_z   = 1'b1;
        upd_c   = 1'b1;
      end
      SRC_REG: begin
        acc_nxt = rd;
        upd_z   = 1'b1;
      end
      SRC_IMM: begin
        acc_nxt = imm_d;
        upd_z   = 1'b1;
      end
      default: acc_nxt = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!CLB) begin
      pc  <= '0;
      ir  <= '0;
      acc <= '0;
      z   <= 1'b0;
      c   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      pc <= pc_nxt;
      if (LoadIR) begin
        ir <= instr_in;
      end
      if (LoadAcc) begin
        acc <= acc_nxt;
        if (upd_z) begin
          z <= (acc_nxt == '0);
        end
        if (upd_c) begin
          c <= alu_cout;
        end
      end
      // Register write captures the accumulator before any same-edge update.
      if (LoadReg) begin
        rf[idx] <= acc;
      end
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: an integer-level reference model checked every cycle,
// plus hand-computed literal expectations along the test plan.
module tb_cpu_datapath;

  logic       clk = 1'b0;
  logic       CLB;
  logic [7:0] instr_in;
  logic [7:0] pc_addr;
  logic       LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0] SelACC;
  logic [3:0] SelALU;
  logic [3:0] op;
  logic       z, c;
  logic [7:0] acc_out;

  always #5 clk = ~clk;

  cpu_datapath #(.DATA_W(8), .ADDR_W(8), .REG_AW(2)) dut (
    .clk(clk), .CLB(CLB), .instr_in(instr_in), .pc_addr(pc_addr),
    .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelACC(SelACC), .SelALU(SelALU),
    .op(op), .z(z), .c(c), .acc_out(acc_out)
  );

  int m_pc, m_ir, m_acc, m_z, m_c;
  int m_r[4];
  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_pc",  pc_addr, m_pc);
      chk("model_op",  op,      m_ir / 16);
      chk("model_acc", acc_out, m_acc);
      chk("model_z",   z,       m_z);
      chk("model_c",   c,       m_c);
    end
  end

  // Model computes the architectural effect of the current strobes, then commits at the edge.
  task automatic tick();
    int a, b, idx, imm, opc, res, cout, cond;
    a    = m_acc;
    idx  = m_ir % 4;
    b    = m_r[idx];
    imm  = m_ir % 16;
    opc  = m_ir / 16;
    res  = a;
    cout = m_c;
    case (SelALU)
      4'b0001: begin res = (a + b) % 256; cout = (a + b > 255); end
      4'b0010: begin res = (a - b + 256) % 256; cout = (a < b); end
      4'b0011: begin res = 255 - (a | b); cout = 0; end
      4'b1011: begin res = (a * 2) % 256; cout = (a >= 128); end
      4'b1100: begin res = a / 2; cout = a % 2; end
      default: begin res = a; cout = m_c; end
    endcase
    if (opc == 6 || opc == 7)       cond = m_z;
    else if (opc == 8 || opc == 10) cond = m_c;
    else                            cond = 0;
    @(posedge clk);
    if (!CLB) begin
      m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
      for (int i = 0; i < 4; i++) m_r[i] = 0;
    end else begin
      if (LoadPC && cond != 0) m_pc = SelPC ? b : imm;
      else if (IncPC)          m_pc = (m_pc + 1) % 256;
      if (LoadReg) m_r[idx] = a;
      if (LoadAcc) begin
        case (SelACC)
          2'b00: begin m_acc = res; m_z = (res == 0); m_c = cout; end
          2'b10: begin m_acc = b;   m_z = (b == 0); end
          2'b11: begin m_acc = imm; m_z = (imm == 0); end
          default: ;
        endcase
      end
      if (LoadIR) m_ir = instr_in;
    end
    #1;
  endtask

  task automatic idle();
    CLB = 1'b1; LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0;
    LoadReg = 0; LoadAcc = 0; SelACC = 2'b00; SelALU = 4'b0000;
  endtask

  task automatic ldir(input logic [7:0] v);
    idle(); instr_in = v; LoadIR = 1; tick();
  endtask

  task automatic ldim(input logic [7:0] v);
    ldir(v); idle(); LoadAcc = 1; SelACC = 2'b11; tick();
  endtask

  task automatic alu(input logic [7:0] v, input logic [3:0] fn);
    ldir(v); idle(); LoadAcc = 1; SelACC = 2'b00; SelALU = fn; tick();
  endtask

  task automatic mova(input logic [7:0] v);
    ldir(v); idle(); LoadReg = 1; tick();
  endtask

  task automatic movr(input logic [7:0] v);
    ldir(v); idle(); LoadAcc = 1; SelACC = 2'b10; tick();
  endtask

  task automatic jmp(input logic [7:0] v, input logic sp);
    ldir(v); idle(); LoadPC = 1; SelPC = sp; tick();
  endtask

  task automatic shl4();
    for (int i = 0; i < 4; i++) alu(8'hB0, 4'hB);
  endtask

  initial begin
    instr_in = 8'h00;
    m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;

    // Power-up reset with strobes asserted.
    idle(); CLB = 0; LoadIR = 1; IncPC = 1; LoadAcc = 1; LoadReg = 1; instr_in = 8'hA5;
    tick(); tick();
    idle();
    chk_on = 1'b1;
    chk("reset_pc", pc_addr, 8'h00);
    chk("reset_acc", acc_out, 8'h00);
    chk("reset_zc", {z, c}, 2'b00);
    chk("reset_op", op, 4'h0);

    // ADD with carry: R1 = 0x20, ACC = 0xF0.
    ldim(8'hD2); shl4(); mova(8'h01);
    ldim(8'hDF); shl4();
    chk("shl_acc_f0", acc_out, 8'hF0);
    alu(8'h11, 4'h1);
    chk("add_acc", acc_out, 8'h10);
    chk("add_c", c, 1'b1);
    chk("add_z", z, 1'b0);

    // SUB equal then borrow.
    ldim(8'hD5); mova(8'h02);
    alu(8'h22, 4'h2);
    chk("sub_eq_acc", acc_out, 8'h00);
    chk("sub_eq_zc", {z, c}, 2'b10);
    ldim(8'hD3); alu(8'h22, 4'h2);
    chk("sub_borrow_acc", acc_out, 8'hFE);
    chk("sub_borrow_c", c, 1'b1);

    // MOVA / MOVR round trip through R3.
    ldim(8'hD7); mova(8'h43);
    ldim(8'hD0); movr(8'h53);
    chk("movr_acc", acc_out, 8'h07);
    chk("movr_zc", {z, c}, 2'b01);

    // Conditional jumps.
    ldim(8'hD0); jmp(8'h7A, 1'b0);
    chk("jzim_taken", pc_addr, 8'h0A);
    ldim(8'hD1); jmp(8'h7A, 1'b0);
    chk("jzim_not_taken", pc_addr, 8'h0A);
    ldim(8'hD4); shl4(); mova(8'h01);
    ldim(8'hD0); alu(8'h21, 4'h2);
    chk("sub_c0_acc", acc_out, 8'hC0);
    jmp(8'h81, 1'b1);
    chk("jcrs_taken", pc_addr, 8'h40);

    // PC wrap and jump-over-increment priority.
    ldim(8'hD0); alu(8'h30, 4'h3);
    chk("nor_acc", acc_out, 8'hFF);
    mova(8'h00);
    ldim(8'hD0); jmp(8'h60, 1'b1);
    chk("jzrs_ff", pc_addr, 8'hFF);
    idle(); IncPC = 1; tick();
    chk("pc_wrap", pc_addr, 8'h00);
    ldir(8'h75);
    idle(); IncPC = 1; LoadPC = 1; SelPC = 0; tick();
    chk("pc_priority", pc_addr, 8'h05);

    // Same-cycle LoadAcc + LoadReg: register receives the old ACC.
    ldir(8'hD1);
    idle(); LoadAcc = 1; SelACC = 2'b11; LoadReg = 1; tick();
    chk("accreg_acc", acc_out, 8'h01);
    movr(8'h01);
    chk("accreg_reg_old", acc_out, 8'h00);

    // LoadIR alongside LoadPC decodes the old IR.
    ldir(8'h73);
    idle(); instr_in = 8'h09; LoadIR = 1; LoadPC = 1; SelPC = 0; tick();
    chk("old_ir_jump", pc_addr, 8'h03);
    chk("new_ir_op", op, 4'h0);

    // Reserved accumulator source and undefined ALU code hold state.
    idle(); LoadAcc = 1; SelACC = 2'b01; tick();
    chk("sel01_z_hold", z, 1'b1);
    ldim(8'hD9); alu(8'h90, 4'h9);
    chk("alu_default_acc", acc_out, 8'h09);

    // Mid-run reset overrides all strobes.
    idle(); CLB = 0; instr_in = 8'hFF; LoadIR = 1; IncPC = 1; LoadPC = 1;
    LoadReg = 1; LoadAcc = 1; SelACC = 2'b11; tick();
    chk("midrst_pc", pc_addr, 8'h00);
    chk("midrst_acc", acc_out, 8'h00);
    chk("midrst_op", op, 4'h0);
    chk("midrst_zc", {z, c}, 2'b00);
    movr(8'h03);
    chk("midrst_r3", acc_out, 8'h00);
    movr(8'h00);
    chk("midrst_r0", acc_out, 8'h00);

    idle(); tick();
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
